// File: rtl/m_w_load_ext.sv
// M/W pipeline register for the load path: latches the M-stage memory word and
// load attributes, then extracts and extends the addressed byte/halfword/word.
module m_w_load_ext (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_Flush,
    input  logic [2:0]  M_LoadOp,
    input  logic        M_IsLoad,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_RData,
    input  logic [31:0] M_WData,
    input  logic        M_RegWrite,
    input  logic [4:0]  M_A3,
    input  logic [31:0] M_PC,
    output logic [31:0] W_Data,
    output logic        W_RegWrite,
    output logic [4:0]  W_A3,
    output logic [31:0] W_PC,
    output logic        W_AdEL
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;

    logic [2:0]  load_op_q;
    logic        is_load_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic [31:0] wdata_q;
    logic        reg_write_q;
    logic [4:0]  a3_q;
    logic [31:0] pc_q;
    logic        adel_q;
    logic        adel_d;

    // Misalignment is decided in M so W only has to register one bit.
    always_comb begin
        adel_d = 1'b0;
        if (M_IsLoad) begin
            case (M_LoadOp)
                OP_LW:         adel_d = (M_Addr[1:0] != 2'b00);
                OP_LHU, OP_LH: adel_d = M_Addr[0];
                default:       adel_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || M_Flush) begin
            load_op_q   <= '0;
            is_load_q   <= 1'b0;
            off_q       <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            reg_write_q <= 1'b0;
            a3_q        <= '0;
            pc_q        <= '0;
            adel_q      <= 1'b0;
        end else begin
            load_op_q   <= M_LoadOp;
            is_load_q   <= M_IsLoad;
            off_q       <= M_Addr[1:0];
            rdata_q     <= M_RData;
            wdata_q     <= M_WData;
            reg_write_q <= M_RegWrite;
            a3_q        <= M_A3;
            pc_q        <= M_PC;
            adel_q      <= adel_d;
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    always_comb begin
        case (load_op_q)
            OP_LW:   ext_data = rdata_q;
            OP_LBU:  ext_data = {24'd0, byte_sel};
            OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LHU:  ext_data = {16'd0, half_sel};
            OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            default: ext_data = '0;
        endcase
    end

    assign W_Data     = is_load_q ? ext_data : wdata_q;
    assign W_RegWrite = reg_write_q & ~adel_q & (a3_q != 5'd0);
    assign W_A3       = a3_q;
    assign W_PC       = pc_q;
    assign W_AdEL     = adel_q;

endmodule

// File: tb/tb_m_w_load_ext.sv
// Bench for m_w_load_ext: directed vector table plus random stimulus checked
// against an arithmetic reference model of the load extraction rules.
module tb_m_w_load_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        M_Flush;
    logic [2:0]  M_LoadOp;
    logic        M_IsLoad;
    logic [31:0] M_Addr;
    logic [31:0] M_RData;
    logic [31:0] M_WData;
    logic        M_RegWrite;
    logic [4:0]  M_A3;
    logic [31:0] M_PC;
    logic [31:0] W_Data;
    logic        W_RegWrite;
    logic [4:0]  W_A3;
    logic [31:0] W_PC;
    logic        W_AdEL;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m_w_load_ext dut (
        .clk(clk), .reset(reset), .M_Flush(M_Flush), .M_LoadOp(M_LoadOp),
        .M_IsLoad(M_IsLoad), .M_Addr(M_Addr), .M_RData(M_RData),
        .M_WData(M_WData), .M_RegWrite(M_RegWrite), .M_A3(M_A3), .M_PC(M_PC),
        .W_Data(W_Data), .W_RegWrite(W_RegWrite), .W_A3(W_A3), .W_PC(W_PC),
        .W_AdEL(W_AdEL)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic [2:0]  op;
        logic        isload;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] pc;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic [4:0]  exp_a3;
        logic        exp_adel;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain shifts and arithmetic on the loaded word.
    function automatic logic [31:0] model_data(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = addr % 4;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd0:    return rdata;
            3'd1:    return b;
            3'd2:    return (b >= 128) ? b - 32'd256 : b;
            3'd3:    return h;
            3'd4:    return (h >= 32768) ? h - 32'd65536 : h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_adel(input logic [2:0] op, input logic isload,
                                        input logic [31:0] addr);
        if (!isload) return 1'b0;
        if (op == 3'd0) return (addr % 4) != 0;
        if (op == 3'd3 || op == 3'd4) return (addr % 2) == 1;
        return 1'b0;
    endfunction

    task automatic drive(input vec_t v);
        reset      = v.rst;
        M_Flush    = v.flush;
        M_LoadOp   = v.op;
        M_IsLoad   = v.isload;
        M_Addr     = v.addr;
        M_RData    = v.rdata;
        M_WData    = v.wdata;
        M_RegWrite = v.rw;
        M_A3       = v.a3;
        M_PC       = v.pc;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        logic [31:0] exp_pc;
        exp_pc = (v.rst || v.flush) ? 32'd0 : v.pc;
        check({tag, ".data"}, W_Data, v.exp_data);
        check({tag, ".rw"},   {31'd0, W_RegWrite}, {31'd0, v.exp_rw});
        check({tag, ".a3"},   {27'd0, W_A3}, {27'd0, v.exp_a3});
        check({tag, ".pc"},   W_PC, exp_pc);
        check({tag, ".adel"}, {31'd0, W_AdEL}, {31'd0, v.exp_adel});
    endtask

    function automatic vec_t mk(input logic rst, input logic flush, input logic [2:0] op,
                                input logic isload, input logic [31:0] addr,
                                input logic [31:0] rdata, input logic [31:0] wdata,
                                input logic rw, input logic [4:0] a3, input logic [31:0] pc,
                                input logic [31:0] ed, input logic erw, input logic [4:0] ea3,
                                input logic eadel);
        vec_t v;
        v.rst = rst; v.flush = flush; v.op = op; v.isload = isload; v.addr = addr;
        v.rdata = rdata; v.wdata = wdata; v.rw = rw; v.a3 = a3; v.pc = pc;
        v.exp_data = ed; v.exp_rw = erw; v.exp_a3 = ea3; v.exp_adel = eadel;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic [31:0] hold_data;

        // rst flush op  ld addr          rdata          wdata          rw a3  pc     -> data           rw a3  adel
        tbl.push_back(mk(1, 0, 3'd2, 1, 32'h0000_0013, 32'hCAFE_F00D, 32'h5555_AAAA, 1, 9,  32'h3000, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 0, 32'h0000_0021, 32'h1357_9BDF, 32'h2468_ACE0, 1, 17, 32'h3004, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1, 8,  32'h3008, 32'hDEADBEEF, 1, 8, 0));
        tbl.push_back(mk(0, 0, 3'd2, 1, 32'h0000_0100, 32'h80FF_7F01, 32'h0,         1, 5,  32'h300C, 32'h00000001, 1, 5, 0));
        tbl.push_back(mk(0, 0, 3'd2, 1, 32'h0000_0101, 32'h80FF_7F01, 32'h0,         1, 5,  32'h3010, 32'h0000007F, 1, 5, 0));
        tbl.push_back(mk(0, 0, 3'd2, 1, 32'h0000_0102, 32'h80FF_7F01, 32'h0,         1, 5,  32'h3014, 32'hFFFFFFFF, 1, 5, 0));
        tbl.push_back(mk(0, 0, 3'd2, 1, 32'h0000_0103, 32'h80FF_7F01, 32'h0,         1, 5,  32'h3018, 32'hFFFFFF80, 1, 5, 0));
        tbl.push_back(mk(0, 0, 3'd1, 1, 32'h0000_0103, 32'h80FF_7F01, 32'h0,         1, 6,  32'h301C, 32'h00000080, 1, 6, 0));
        tbl.push_back(mk(0, 0, 3'd4, 1, 32'h0000_0200, 32'h8001_FFFE, 32'h0,         1, 7,  32'h3020, 32'hFFFFFFFE, 1, 7, 0));
        tbl.push_back(mk(0, 0, 3'd4, 1, 32'h0000_0202, 32'h8001_FFFE, 32'h0,         1, 7,  32'h3024, 32'hFFFF8001, 1, 7, 0));
        tbl.push_back(mk(0, 0, 3'd3, 1, 32'h0000_0202, 32'h8001_FFFE, 32'h0,         1, 7,  32'h3028, 32'h00008001, 1, 7, 0));
        tbl.push_back(mk(0, 0, 3'd0, 1, 32'h0000_0102, 32'h1122_3344, 32'h0,         1, 10, 32'h302C, 32'h11223344, 0, 10, 1));
        tbl.push_back(mk(0, 0, 3'd4, 1, 32'h0000_0101, 32'h0000_C0DE, 32'h0,         1, 11, 32'h3030, 32'hFFFFC0DE, 0, 11, 1));
        tbl.push_back(mk(0, 0, 3'd2, 1, 32'h0000_0103, 32'hAB00_0000, 32'h0,         1, 12, 32'h3034, 32'hFFFFFFAB, 1, 12, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 32'h0000_0003, 32'hFFFF_FFFF, 32'h1234_5678, 1, 31, 32'h3038, 32'h12345678, 1, 31, 0));
        tbl.push_back(mk(0, 1, 3'd0, 0, 32'h0000_0003, 32'hFFFF_FFFF, 32'h1234_5678, 1, 31, 32'h303C, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd0, 1, 32'h0000_0400, 32'h7654_3210, 32'h0,         1, 0,  32'h3040, 32'h76543210, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3'd0, 1, 32'h0000_0400, 32'h7654_3210, 32'h0,         1, 3,  32'h3044, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd6, 1, 32'h0000_0400, 32'h7654_3210, 32'h9999_9999, 1, 4,  32'h3048, 32'h0, 1, 4, 0));
        tbl.push_back(mk(0, 0, 3'd3, 1, 32'h0000_0201, 32'h8001_FFFE, 32'h0,         1, 13, 32'h304C, 32'h0000FFFE, 0, 13, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), tbl[i]);
        end

        // Outputs must not follow M inputs between edges.
        v = mk(0, 0, 3'd1, 1, 32'h0000_0001, 32'h0000_A500, 32'h0, 1, 20, 32'h4000,
               32'h000000A5, 1, 20, 0);
        drive(v);
        @(posedge clk);
        #1;
        check_outputs("comb0", v);
        hold_data = W_Data;
        M_RData  = 32'hFFFF_FFFF;
        M_LoadOp = 3'd2;
        M_Addr   = 32'h0000_0003;
        M_Flush  = 1'b1;
        #2;
        check("comb_hold", W_Data, hold_data);
        check_outputs("comb1", v);

        // Random stream against the reference model.
        for (int i = 0; i < 400; i++) begin
            vec_t r;
            r.rst    = ($urandom_range(0, 31) == 0);
            r.flush  = ($urandom_range(0, 15) == 0);
            r.op     = 3'($urandom_range(0, 7));
            r.isload = ($urandom_range(0, 3) != 0);
            r.addr   = $urandom;
            r.rdata  = $urandom;
            r.wdata  = $urandom;
            r.rw     = ($urandom_range(0, 7) != 0);
            r.a3     = 5'($urandom_range(0, 31));
            r.pc     = $urandom;
            if (r.rst || r.flush) begin
                r.exp_data = 32'd0; r.exp_rw = 1'b0; r.exp_a3 = 5'd0; r.exp_adel = 1'b0;
            end else begin
                r.exp_adel = model_adel(r.op, r.isload, r.addr);
                r.exp_data = r.isload ? model_data(r.op, r.addr, r.rdata) : r.wdata;
                r.exp_a3   = r.a3;
                r.exp_rw   = r.rw && !r.exp_adel && (r.a3 != 5'd0);
            end
            drive(r);
            @(posedge clk);
            #1;
            check_outputs($sformatf("rnd%0d", i), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_w_load_ext.md
# m_w_load_ext

Memory-to-writeback load path for the 5-stage MIPS pipeline. It is the read-side counterpart of the immediate/store datapath: it latches the M-stage data-memory read word, address byte offset and load type into the M/W pipeline register. It then extracts and sign/zero-extends the addressed byte, halfword or word into the 32-bit value written back to the GRF. It also flags misaligned loads and suppresses their register write.

## Interface
Parameters:
- none

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- M_Flush  input  1  inserts a bubble into W on the next edge; sync, active-high
- M_LoadOp  input  3  000 LW, 001 LBU, 010 LB, 011 LHU, 100 LH, 101–111 reserved
- M_IsLoad  input  1  the M instruction is a load; when 0 the data passes through unextended (ALU/link result)
- M_Addr  input  32  effective address (ALU result) in M
- M_RData  input  32  word read from DM at {M_Addr[31:2],2'b00}
- M_WData  input  32  non-load result forwarded from M (ALU result / PC+8)
- M_RegWrite  input  1  write-enable of the M instruction
- M_A3  input  5  destination register of the M instruction
- M_PC  input  32  PC of the M instruction
- W_Data  output  32  value to write to GRF[W_A3]
- W_RegWrite  output  1  GRF write-enable, forced 0 on misaligned load or when W_A3 = 0
- W_A3  output  5  destination register
- W_PC  output  32  PC of the W instruction, for write tracing
- W_AdEL  output  1  the W instruction is a misaligned load

## Operation
- State: registered copy of every M_* input except M_Flush, plus the W_AdEL bit. Combinational extraction in W acts on the registered fields only.
- Each rising edge:
  - if reset, all registers go to 0;
  - else if M_Flush, all registers go to 0 (bubble);
  - else all registers load their M_* inputs.
- Misalignment, computed in M and registered as W_AdEL: M_IsLoad and ((LW and Addr[1:0]≠0) or ((LH or LHU) and Addr[0]=1)). Byte loads are never misaligned.
- Extraction, with off = registered Addr[1:0] and d = registered RData:
  - LW: d.
  - LBU: zero-extended d[8·off+7 : 8·off].
  - LB: sign-extended byte, bit 7 of the byte replicated into bits 31:8.
  - LHU: zero-extended d[16·off[1]+15 : 16·off[1]].
  - LH: the same halfword, sign-extended from bit 15.
  - Reserved op codes yield 0.
- W_Data selects the extraction result when the registered IsLoad is 1, otherwise the registered WData.
- W_RegWrite is the registered RegWrite AND NOT W_AdEL AND (W_A3≠0).
- W_Data is still driven on a misaligned load, using the extraction of the truncated offset, but it is never written.

## Timing
- Latency is exactly 1 cycle from M inputs to W outputs. There is no stall input: W always advances.
- Reset value of every output is 0: W_Data=0, W_RegWrite=0, W_A3=0, W_PC=0, W_AdEL=0.
- Simultaneous reset and M_Flush: reset wins, with the same result (all 0).
- Reset asserted mid-stream discards the in-flight M instruction. The first valid W output appears 1 cycle after reset deasserts with a valid M instruction.
- Back-to-back loads are accepted every cycle with no bubble. Forwarding from W uses W_Data in the same cycle it appears.
- All outputs depend only on registers. There is no combinational path from any M_* input to any W_* output.

## Test plan
- Reset: drive random M_*, hold reset 2 cycles, then check all outputs are 0. Release with LW, Addr=0x100, RData=0xDEADBEEF, A3=8, RegWrite=1. Next cycle requires W_Data=0xDEADBEEF, W_RegWrite=1, W_A3=8.
- Byte loads: RData=0x80FF7F01, one per cycle. LB at off 0,1,2,3 must give 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU at off 3 must give 0x00000080. Check every cycle with no bubbles.
- Halfword loads: RData=0x8001FFFE. LH at off 0 must give 0xFFFFFFFE. LH at off 2 must give 0xFFFF8001. LHU at off 2 must give 0x00008001.
- Misalignment: LW at Addr=0x102, then LH at Addr=0x101. Both require W_AdEL=1 and W_RegWrite=0. A following LB at Addr=0x103 requires W_AdEL=0.
- Flush and pass-through: non-load with WData=0x12345678, A3=31 must give W_Data=0x12345678, W_RegWrite=1. The same instruction with M_Flush=1 must give all outputs 0. Any write with A3=0 must give W_RegWrite=0.
